// File: rtl/seq_001001_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_001001_gen_if
//  Brief    : Control/status bundle between an upstream requester and the
//             001001 serial pattern generator.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_001001_gen_if #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             abort;
    logic             dout;
    logic             dvalid;
    logic             frame_start;
    logic             busy;
    logic             done;

    // Requester side: issues bursts and observes the serial line.
    modport master (
        output start, rep_cnt, gap_len, abort,
        input  dout, dvalid, frame_start, busy, done
    );

    // Generator side.
    modport slave (
        input  start, rep_cnt, gap_len, abort,
        output dout, dvalid, frame_start, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_001001_gen.sv
`default_nettype none
// ============================================================================
//  Module   : seq_001001_gen
//  Brief    : Serial pattern generator. Emits PATTERN MSB-first a latched
//             number of times, optionally separated by a latched idle gap,
//             with start/busy/done handshake, per-repetition framing and a
//             synchronous abort. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_001001_gen #(
    parameter int             PAT_W    = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b001001,
    parameter int             CNT_W    = 4,
    parameter int             GAP_W    = 3,
    parameter logic           IDLE_BIT = 1'b0
) (
    input  wire               clk,
    input  wire               rst,
    seq_001001_gen_if.slave   bus
);

    localparam int              IDX_W    = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;          // bit index of the bit on the line
    logic [CNT_W-1:0] rem_q, rem_d;          // repetitions left, including current
    logic [GAP_W-1:0] gap_q, gap_d;          // latched gap length
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;  // gap cycles left after the current one
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Pattern reordered so that index 0 is the first bit on the wire.
    logic [PAT_W-1:0] w_pat_rev;

    for (genvar i = 0; i < PAT_W; i++) begin : g_rev
        assign w_pat_rev[i] = PATTERN[PAT_W-1-i];
    end

    // Next-state and next-output logic; the state register holds what the
    // line shows in the current cycle, so outputs follow directly from state_d.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rem_d         = rem_q;
        gap_d         = gap_q;
        gap_cnt_d     = gap_cnt_q;
        dout_d        = IDLE_BIT;
        dvalid_d      = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort in IDLE suppresses a simultaneous start.
                if (bus.start && !bus.abort && (bus.rep_cnt != '0)) begin
                    rem_d   = bus.rep_cnt;
                    gap_d   = bus.gap_len;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    rem_d   = '0;
                end else if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                end else if (rem_q != CNT_W'(1)) begin
                    if (gap_q == '0) begin
                        // Back-to-back: next repetition starts with no bubble.
                        rem_d = rem_q - 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_q - 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    rem_d   = '0;
                    done_d  = 1'b1;
                end
            end

            S_GAP: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    rem_d     = '0;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_SEND;
                    rem_d   = rem_q - 1'b1;
                    idx_d   = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_SEND) begin
            dout_d        = w_pat_rev[idx_d];
            dvalid_d      = 1'b1;
            busy_d        = 1'b1;
            frame_start_d = (idx_d == '0);
        end else if (state_d == S_GAP) begin
            busy_d = 1'b1;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            rem_q         <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            dout_q        <= IDLE_BIT;
            dvalid_q      <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rem_q         <= rem_d;
            gap_q         <= gap_d;
            gap_cnt_q     <= gap_cnt_d;
            dout_q        <= dout_d;
            dvalid_q      <= dvalid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.dvalid      = dvalid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_001001_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_001001_gen
//  Brief    : Self-checking bench for seq_001001_gen: per-cycle vector table
//             plus hand-written burst, abort, back-to-back and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_001001_gen;

    localparam int PAT_W = 6;
    localparam int CNT_W = 4;
    localparam int GAP_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_001001_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    seq_001001_gen #(
        .PAT_W   (PAT_W),
        .PATTERN (6'b001001),
        .CNT_W   (CNT_W),
        .GAP_W   (GAP_W),
        .IDLE_BIT(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_pat = 6'b001001;

    // exp = {dout, dvalid, frame_start, busy, done}
    typedef struct {
        logic             rst;
        logic             start;
        logic             abort;
        logic [CNT_W-1:0] rep;
        logic [GAP_W-1:0] gap;
        logic [4:0]       exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic a,
                                input int rep, input int gap, input logic [4:0] e);
        vec_t v;
        v.rst   = r;
        v.start = s;
        v.abort = a;
        v.rep   = CNT_W'(rep);
        v.gap   = GAP_W'(gap);
        v.exp   = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.dout, bus.dvalid, bus.frame_start, bus.busy, bus.done});
    endfunction

    // Issue one burst and check its bit stream, framing and timing.
    task automatic run_burst(input int n, input int g, input string tag);
        int bits     = 0;
        int fs       = 0;
        int busy_c   = 0;
        int done_cyc = -1;
        int bad      = 0;
        bus.start   = 1'b1;
        bus.rep_cnt = CNT_W'(n);
        bus.gap_len = GAP_W'(g);
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (bus.dvalid) begin
                if (bus.dout !== exp_pat[5 - (bits % PAT_W)]) bad++;
                bits++;
            end else if (bus.dout !== 1'b0) begin
                bad++;
            end
            if (bus.frame_start) begin
                fs++;
                if (!bus.dvalid || ((bits - 1) % PAT_W) != 0) bad++;
            end
            if (bus.busy) busy_c++;
            if (bus.done) begin
                if (bus.busy) bad++;
                done_cyc = c;
                break;
            end
            tick();
        end
        chk({tag, "_bits"}, bits, n * PAT_W);
        chk({tag, "_frames"}, fs, n);
        chk({tag, "_busy_cycles"}, busy_c, n * PAT_W + (n - 1) * g);
        chk({tag, "_done_cycle"}, done_cyc, 1 + n * PAT_W + (n - 1) * g);
        chk({tag, "_stream_errs"}, bad, 0);
        tick();
        chk({tag, "_after_done"}, outs(), 0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.rep_cnt = '0;
        bus.gap_len = '0;

        // Reset, single burst, rep_cnt=0, abort/start collision in IDLE.
        tbl.push_back(mk(1, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(0, 1, 0, 1, 0, 5'b01110));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'b11010));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'b11010));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'b00001));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'b00000));
        tbl.push_back(mk(0, 1, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk(0, 1, 1, 1, 0, 5'b00000));
        tbl.push_back(mk(0, 0, 0, 1, 0, 5'b00000));
        // rep_cnt=2, gap=1; starts with new values during SEND and GAP ignored.
        tbl.push_back(mk(0, 1, 0, 2, 1, 5'b01110));
        tbl.push_back(mk(0, 1, 0, 7, 0, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 7, 0, 5'b11010));
        tbl.push_back(mk(0, 0, 0, 7, 0, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 7, 0, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 7, 0, 5'b11010));
        tbl.push_back(mk(0, 1, 0, 7, 5, 5'b00010));
        tbl.push_back(mk(0, 0, 0, 7, 5, 5'b01110));
        tbl.push_back(mk(0, 0, 0, 7, 5, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 7, 5, 5'b11010));
        tbl.push_back(mk(0, 0, 0, 7, 5, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 7, 5, 5'b01010));
        tbl.push_back(mk(0, 0, 0, 7, 5, 5'b11010));
        tbl.push_back(mk(0, 0, 0, 7, 5, 5'b00001));
        tbl.push_back(mk(0, 0, 0, 7, 5, 5'b00000));

        for (int i = 0; i < tbl.size(); i++) begin
            rst         = tbl[i].rst;
            bus.start   = tbl[i].start;
            bus.abort   = tbl[i].abort;
            bus.rep_cnt = tbl[i].rep;
            bus.gap_len = tbl[i].gap;
            tick();
            chk($sformatf("vec%0d", i), outs(), int'(tbl[i].exp));
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // Three repetitions separated by two idle cycles.
        run_burst(3, 2, "rep3_gap2");

        // Abort on the 3rd bit of the 2nd repetition.
        bus.start   = 1'b1;
        bus.rep_cnt = CNT_W'(2);
        bus.gap_len = GAP_W'(0);
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 9; c++) tick();
        chk("abort_pre_bit", outs(), int'(5'b11010));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_next", outs(), 0);
        tick();
        chk("abort_no_done", outs(), 0);
        run_burst(1, 0, "after_abort");

        // start held across done: second burst begins right after done.
        bus.start   = 1'b1;
        bus.rep_cnt = CNT_W'(1);
        bus.gap_len = GAP_W'(0);
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk($sformatf("b2b_c%0d", c), int'({bus.dvalid, bus.frame_start, bus.done}),
                int'({(c != 7 && c != 14), (c == 1 || c == 8), (c == 7 || c == 14)}));
            if (c == 8) bus.start = 1'b0;
        end
        tick();
        chk("b2b_idle", outs(), 0);

        // Reset in the middle of a gap.
        bus.start   = 1'b1;
        bus.rep_cnt = CNT_W'(3);
        bus.gap_len = GAP_W'(4);
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 8; c++) tick();
        chk("rst_gap_pre", outs(), int'(5'b00010));
        rst = 1'b1;
        tick();
        chk("rst_gap_out", outs(), 0);
        rst = 1'b0;
        tick();
        chk("rst_gap_idle", outs(), 0);

        // Reset in the middle of a repetition.
        bus.start   = 1'b1;
        bus.rep_cnt = CNT_W'(2);
        bus.gap_len = GAP_W'(0);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("rst_send_pre", outs(), int'(5'b11010));
        rst = 1'b1;
        tick();
        chk("rst_send_out", outs(), 0);
        rst = 1'b0;
        tick();
        chk("rst_send_idle", outs(), 0);

        // Maximum repetition count with maximum gap.
        run_burst(15, 7, "rep15_gap7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_001001_gen.md
# seq_001001_gen

Serial pattern generator for the 001001 sequence link, driving the single-bit line that the 001001 sequence detector samples. On a start request it emits a parameterised pattern (default 6'b001001) MSB-first, a latched number of times. Repetitions are either back-to-back or separated by a latched number of idle cycles. It provides start/busy/done handshaking, per-repetition framing and a synchronous abort, so benches and upstream logic can produce clean detector stimulus.

## Interface
- PAT_W, 6, pattern length in bits (≥2)
- PATTERN, 6'b001001, bits sent MSB (bit PAT_W-1) first
- CNT_W, 4, width of repetition count
- GAP_W, 3, width of inter-repetition gap length
- IDLE_BIT, 1'b0, dout level whenever no pattern bit is driven
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- rep_cnt  input  CNT_W  repetitions to send; latched on accepted start
- gap_len  input  GAP_W  idle cycles between repetitions; latched on accepted start
- abort  input  1  synchronous cancel; priority over everything except rst
- dout  output  1  serial data line
- dvalid  output  1  high exactly while dout carries a pattern bit
- frame_start  output  1  1-cycle pulse with the first bit of each repetition
- busy  output  1  high from first bit through last bit, including gaps
- done  output  1  1-cycle pulse after the last bit of the last repetition

## Operation
- All outputs are registered. Reset values: dout=IDLE_BIT, dvalid=0, frame_start=0, busy=0, done=0, state=IDLE, counters=0.
- States:
  - IDLE: dout=IDLE_BIT, dvalid=0, busy=0. When start=1 and rep_cnt≠0, latch rep_cnt/gap_len, clear bit index, go to SEND. When start=1 and rep_cnt=0, ignore the request: no busy, no done.
  - SEND: drive PATTERN[PAT_W-1-idx] with dvalid=1 and busy=1. frame_start=1 when idx=0. After idx=PAT_W-1:
    - If repetitions remain and gap=0, go directly to the next repetition's idx=0 with no bubble.
    - If repetitions remain and gap>0, go to GAP.
    - If this was the last repetition, go to IDLE and pulse done.
  - GAP: dout=IDLE_BIT, dvalid=0, busy=1 for exactly gap_len cycles, then return to SEND with idx=0.
- start while busy (SEND/GAP) is ignored. Latched values are unaffected by input changes mid-operation.
- start is accepted in the same cycle done is high, because the block is in IDLE then. This gives back-to-back bursts with no dead cycle beyond the done cycle.
- abort=1 in SEND or GAP: next cycle is IDLE with dout=IDLE_BIT, dvalid=0, busy=0, and no done pulse. abort in IDLE has no effect, and an abort/start collision in IDLE ignores start.
- rst mid-operation returns every output to its reset value on the next edge.
- The repetition counter counts down. rep_cnt=2^CNT_W-1 is legal and must not wrap.

## Timing
- start sampled high at edge t (IDLE, rep_cnt=N≥1, gap_len=g): the first bit is visible after edge t+1, and busy/frame_start rise at the same time.
- Bit k (0-based) of repetition r (0-based) is visible after edge t+1+r·(PAT_W+g)+k.
- The last bit is visible after edge t+N·PAT_W+(N-1)·g.
- done is high for one cycle after edge t+1+N·PAT_W+(N-1)·g, with busy=0 in that cycle.
- frame_start pulses exactly N times per burst. dvalid is high for exactly N·PAT_W cycles.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then start with rep_cnt=1, gap_len=0: dout=0,0,1,0,0,1 on 6 consecutive cycles with dvalid=1 and frame_start on the first bit only. done pulses one cycle later, then the line returns to 0. The 001001 detector asserts once.
- rep_cnt=3, gap_len=2: 3×6 pattern bits with two IDLE_BIT/dvalid=0 cycles between repetitions. busy stays high for 22 cycles, frame_start pulses 3 times, done pulses once.
- rep_cnt=0 with start: no busy and no done. A start pulse during SEND and GAP is ignored, and the burst length is unchanged.
- abort on the 3rd bit of the 2nd repetition (rep_cnt=2): next cycle dout=0, dvalid=0, busy=0, with no done. A fresh start two cycles later produces a complete burst.
- start held high across done (rep_cnt=1, gap_len=0): second burst's first bit appears the cycle after done. Total 6 bits, 1 cycle done, 6 bits.
- rst asserted mid-GAP and mid-SEND: all outputs take their reset values on the next edge. rep_cnt=15, gap_len=7 runs to completion with exactly 90 valid bits.
